stack_ctrl: RTL and testbench

Stack controller that owns the stack pointer and drives the `memstack` RAM port (`we`, `a`, `data_in`, `data_out`) on behalf of the processor datapath. It converts push/pop requests into single-cycle RAM accesses and returns popped words registered on `dout`. It reports full/empty status and keeps sticky overflow/underflow flags. It sits between the control unit (CALL/RET, PUSH/POP instructions) and `memstack`.

---
 rtl/stack_ctrl_if.sv | 25 ++
 rtl/stack_ctrl.sv | 127 ++++++++++++
 tb/tb_stack_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_if.sv
// Request/response bundle between the control unit (master) and stack_ctrl (slave).
interface stack_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             push;
   logic             pop;
   logic             clr_err;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             full;
   logic             empty;
   logic             ovf;
   logic             unf;

   modport master (
      output push, pop, clr_err, din,
      input  dout, dout_valid, full, empty, ovf, unf
   );

   modport slave (
      input  push, pop, clr_err, din,
      output dout, dout_valid, full, empty, ovf, unf
   );
endinterface

// File: rtl/stack_ctrl.sv
// Stack pointer owner driving the memstack RAM port; optional STACK_PEEK_EN adds o_top/o_level.
module stack_ctrl #(
   parameter int WIDTH     = 16,
   parameter int ELEMENTOS = 1024
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   stack_ctrl_if.slave                  bus,
   output logic                         o_mem_we,
   output logic [$clog2(ELEMENTOS)-1:0] o_mem_a,
   output logic [WIDTH-1:0]             o_mem_din,
   input  logic [WIDTH-1:0]             i_mem_dout
`ifdef STACK_PEEK_EN
   ,
   output logic [WIDTH-1:0]             o_top,
   output logic [$clog2(ELEMENTOS):0]   o_level
`endif
);

   localparam int AW = $clog2(ELEMENTOS);

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_REPL = 2'b11
   } op_e;

   logic [AW:0]      r_sp;
   logic [WIDTH-1:0] r_dout;
   logic             r_dout_valid;
   logic             r_ovf;
   logic             r_unf;

   op_e              w_op;
   logic             w_full;
   logic             w_empty;
   logic [AW-1:0]    w_top_a;
   logic [AW:0]      w_sp_nxt;
   logic             w_pop_ok;
   logic             w_set_ovf;
   logic             w_set_unf;
   logic             w_we;
   logic [AW-1:0]    w_a;

   assign w_op    = op_e'({bus.push, bus.pop});
   assign w_full  = (r_sp == (AW+1)'(ELEMENTOS));
   assign w_empty = (r_sp == '0);
   assign w_top_a = r_sp[AW-1:0] - AW'(1);

   always_comb begin
      w_we      = 1'b0;
      w_a       = w_top_a;
      w_sp_nxt  = r_sp;
      w_pop_ok  = 1'b0;
      w_set_ovf = 1'b0;
      w_set_unf = 1'b0;
      case (w_op)
         OP_PUSH: begin
            if (!w_full) begin
               w_we     = 1'b1;
               w_a      = r_sp[AW-1:0];
               w_sp_nxt = r_sp + (AW+1)'(1);
            end else begin
               w_set_ovf = 1'b1;
            end
         end
         OP_POP: begin
            if (!w_empty) begin
               w_pop_ok = 1'b1;
               w_sp_nxt = r_sp - (AW+1)'(1);
            end else begin
               w_set_unf = 1'b1;
            end
         end
         OP_REPL: begin
            w_we = 1'b1;
            if (!w_empty) begin
               w_pop_ok = 1'b1;
            end else begin
               // Replace on an empty stack degrades to a push (never full here).
               w_a       = r_sp[AW-1:0];
               w_sp_nxt  = r_sp + (AW+1)'(1);
               w_set_unf = 1'b1;
            end
         end
         default: ;
      endcase
      if (i_reset) begin
         w_we = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sp         <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_ovf        <= 1'b0;
         r_unf        <= 1'b0;
      end else begin
         r_sp         <= w_sp_nxt;
         r_dout_valid <= w_pop_ok;
         if (w_pop_ok) begin
            r_dout <= i_mem_dout;
         end
         r_ovf <= w_set_ovf | (r_ovf & ~bus.clr_err);
         r_unf <= w_set_unf | (r_unf & ~bus.clr_err);
      end
   end

   assign o_mem_we       = w_we;
   assign o_mem_a        = w_a;
   assign o_mem_din      = bus.din;
   assign bus.dout       = r_dout;
   assign bus.dout_valid = r_dout_valid;
   assign bus.full       = w_full;
   assign bus.empty      = w_empty;
   assign bus.ovf        = r_ovf;
   assign bus.unf        = r_unf;

`ifdef STACK_PEEK_EN
   assign o_top   = (w_op == OP_IDLE && !w_empty) ? i_mem_dout : '0;
   assign o_level = r_sp;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed table plus randomized run of stack_ctrl against a queue-based stack model.
module tb_stack_ctrl;
   localparam int W  = 16;
   localparam int EL = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_we;
   logic [1:0]    mem_a;
   logic [W-1:0]  mem_din;
   logic [W-1:0]  mem_dout;
   logic [W-1:0]  ram [EL];
`ifdef STACK_PEEK_EN
   logic [W-1:0]  top;
   logic [2:0]    level;
`endif

   int n_cmp = 0;
   int n_err = 0;

   stack_ctrl_if #(.WIDTH(W)) bus ();

   stack_ctrl #(.WIDTH(W), .ELEMENTOS(EL)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .bus        (bus.slave),
      .o_mem_we   (mem_we),
      .o_mem_a    (mem_a),
      .o_mem_din  (mem_din),
      .i_mem_dout (mem_dout)
`ifdef STACK_PEEK_EN
      ,
      .o_top      (top),
      .o_level    (level)
`endif
   );

   always #5 clk = ~clk;

   // memstack stand-in: synchronous write, combinational read
   always @(posedge clk) if (mem_we) ram[mem_a] <= mem_din;
   assign mem_dout = ram[mem_a];

   // reference model: the stack as a queue, top at the back
   logic [W-1:0] q[$];
   logic         m_ovf, m_unf, m_valid;
   logic [W-1:0] m_dout;

   typedef struct {
      logic         rst, ps, pp, cl;
      logic [W-1:0] din;
      logic [W-1:0] dout;
      logic         valid, full, empty, ovf, unf;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic rst, input logic ps, input logic pp, input logic cl,
                       input logic [W-1:0] d);
      int n;
      logic ex_we;
      int ex_a;
      reset = rst; bus.push = ps; bus.pop = pp; bus.clr_err = cl; bus.din = d;
      #1;
      n     = q.size();
      ex_we = 1'b0;
      ex_a  = (n - 1) & (EL - 1);
      if (ps && !pp && n < EL) begin ex_we = 1'b1; ex_a = n; end
      if (ps && pp) begin ex_we = 1'b1; ex_a = (n > 0) ? n - 1 : 0; end
      if (rst) ex_we = 1'b0;
      check("mem_we", {31'd0, mem_we}, {31'd0, ex_we});
      check("mem_a", {30'd0, mem_a}, ex_a);
      if (ex_we) check("mem_din", {16'd0, mem_din}, {16'd0, d});
      @(posedge clk);
      if (rst) begin
         q.delete(); m_ovf = 0; m_unf = 0; m_dout = '0; m_valid = 0;
      end else begin
         logic so, su;
         so = 0; su = 0; m_valid = 0;
         if (ps && !pp) begin
            if (n < EL) q.push_back(d); else so = 1;
         end else if (!ps && pp) begin
            if (n > 0) begin m_dout = q.pop_back(); m_valid = 1; end else su = 1;
         end else if (ps && pp) begin
            if (n > 0) begin m_dout = q[n-1]; q[n-1] = d; m_valid = 1; end
            else begin q.push_back(d); su = 1; end
         end
         m_ovf = so | (m_ovf & !cl);
         m_unf = su | (m_unf & !cl);
      end
      #1;
      check("dout", {16'd0, bus.dout}, {16'd0, m_dout});
      check("dout_valid", {31'd0, bus.dout_valid}, {31'd0, m_valid});
      check("full", {31'd0, bus.full}, {31'd0, q.size() == EL});
      check("empty", {31'd0, bus.empty}, {31'd0, q.size() == 0});
      check("ovf", {31'd0, bus.ovf}, {31'd0, m_ovf});
      check("unf", {31'd0, bus.unf}, {31'd0, m_unf});
   endtask

   vec_t tbl[$];

   function automatic vec_t v(input logic rst, ps, pp, cl, input logic [W-1:0] din,
                              input logic [W-1:0] dout, input logic valid, full, empty, ovf, unf);
      vec_t r;
      r.rst = rst; r.ps = ps; r.pp = pp; r.cl = cl; r.din = din; r.dout = dout;
      r.valid = valid; r.full = full; r.empty = empty; r.ovf = ovf; r.unf = unf;
      return r;
   endfunction

   initial begin
      for (int i = 0; i < EL; i++) ram[i] = '0;
      m_ovf = 0; m_unf = 0; m_valid = 0; m_dout = '0;
      reset = 1; bus.push = 0; bus.pop = 0; bus.clr_err = 0; bus.din = '0;

      //          rst ps pp cl din      dout     v  f  e  o  u
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'h1111, 16'h0000, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'h2222, 16'h0000, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'h3333, 16'h0000, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h3333, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h2222, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h1111, 1, 0, 1, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'h00A1, 16'h1111, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'h00A2, 16'h1111, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'h00A3, 16'h1111, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'h00A4, 16'h1111, 0, 1, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'hDEAD, 16'h1111, 0, 1, 0, 1, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h00A4, 1, 0, 0, 1, 0));
      tbl.push_back(v(0, 0, 0, 1, 16'h0000, 16'h00A4, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h00A3, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h00A2, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h00A1, 1, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h00A1, 0, 0, 1, 0, 1));
      tbl.push_back(v(0, 1, 1, 0, 16'h00AA, 16'h00A1, 0, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h00AA, 1, 0, 1, 0, 1));
      tbl.push_back(v(0, 0, 0, 1, 16'h0000, 16'h00AA, 0, 0, 1, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'h1234, 16'h00AA, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 0, 16'h5678, 16'h1234, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h5678, 1, 0, 1, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'h0001, 16'h5678, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'h0002, 16'h5678, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 1, 0, 0, 16'h0003, 16'h0000, 0, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 1));
      tbl.push_back(v(0, 1, 0, 0, 16'h00B1, 16'h0000, 0, 0, 0, 0, 1));
      tbl.push_back(v(0, 1, 0, 0, 16'h00B2, 16'h0000, 0, 0, 0, 0, 1));
      tbl.push_back(v(0, 1, 0, 0, 16'h00B3, 16'h0000, 0, 0, 0, 0, 1));
      tbl.push_back(v(0, 1, 0, 0, 16'h00B4, 16'h0000, 0, 1, 0, 0, 1));
      tbl.push_back(v(0, 1, 0, 1, 16'hDEAD, 16'h0000, 0, 1, 0, 1, 0));
      tbl.push_back(v(0, 1, 1, 0, 16'hCAFE, 16'h00B4, 1, 1, 0, 1, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'hCAFE, 1, 0, 0, 1, 0));

      @(negedge clk);
      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].ps, tbl[i].pp, tbl[i].cl, tbl[i].din);
         check($sformatf("tbl%0d.dout", i), {16'd0, bus.dout}, {16'd0, tbl[i].dout});
         check($sformatf("tbl%0d.valid", i), {31'd0, bus.dout_valid}, {31'd0, tbl[i].valid});
         check($sformatf("tbl%0d.full", i), {31'd0, bus.full}, {31'd0, tbl[i].full});
         check($sformatf("tbl%0d.empty", i), {31'd0, bus.empty}, {31'd0, tbl[i].empty});
         check($sformatf("tbl%0d.ovf", i), {31'd0, bus.ovf}, {31'd0, tbl[i].ovf});
         check($sformatf("tbl%0d.unf", i), {31'd0, bus.unf}, {31'd0, tbl[i].unf});
      end

`ifdef STACK_PEEK_EN
      step(1, 0, 0, 0, 16'h0000);
      step(0, 1, 0, 0, 16'hBEEF);
      reset = 0; bus.push = 0; bus.pop = 0; bus.clr_err = 0;
      #1;
      check("peek_top", {16'd0, top}, 32'h0000BEEF);
      check("peek_level", {29'd0, level}, 32'd1);
`endif

      for (int i = 0; i < 3000; i++) begin
         logic [1:0] op;
         op = 2'($urandom_range(0, 3));
         step(($urandom_range(0, 63) == 0), op[1], op[0], ($urandom_range(0, 15) == 0),
              16'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
